// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - shared fade state type and duty stepping helpers for led_fader
package led_fader_pkg;

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      ON        = 2'd2,
      RAMP_DOWN = 2'd3
   } fade_state_t;

   // Steps duty toward target by at most step; differences are compared so nothing overflows.
   function automatic int unsigned sat_step(input int unsigned duty,
                                            input int unsigned target,
                                            input int unsigned step);
      int unsigned r;
      r = duty;
      if (duty < target) begin
         r = ((target - duty) > step) ? duty + step : target;
      end else if (duty > target) begin
         r = ((duty - target) > step) ? duty - step : target;
      end
      return r;
   endfunction

   function automatic fade_state_t classify(input int unsigned duty,
                                            input int unsigned target);
      fade_state_t s;
      if (duty < target) begin
         s = RAMP_UP;
      end else if (duty > target) begin
         s = RAMP_DOWN;
      end else if (duty == 0) begin
         s = OFF;
      end else begin
         s = ON;
      end
      return s;
   endfunction

endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one fading PWM channel: target, duty ramp, state and compare output
// Optional square-law brightness curve when LED_FADER_GAMMA_EN is defined.
module led_fader_channel
   import led_fader_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int FADE_STEP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pattern,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                wrap,
   output logic                led,
   output logic                fading
);

   logic [PWM_BITS-1:0] target;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_next;
   logic [PWM_BITS-1:0] eff_duty;
   fade_state_t         state;
   fade_state_t         state_next;

   always_comb begin
      duty_next  = PWM_BITS'(sat_step(32'(duty), 32'(target), 32'(FADE_STEP)));
      state_next = classify(32'(duty), 32'(target));
   end

`ifdef LED_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;
   assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
   assign eff_duty = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign eff_duty = duty;
`endif

   // Duty only moves on the wrap tick so each PWM period sees a single stable level.
   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         duty   <= '0;
         state  <= OFF;
         led    <= 1'b0;
      end else begin
         target <= pattern ? brightness : '0;
         if (wrap) begin
            duty <= duty_next;
         end
         state <= state_next;
         led   <= (eff_duty > pwm_cnt);
      end
   end

   assign fading = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - per-channel fading PWM LED driver with shared prescaler and PWM timebase
// Define LED_FADER_GAMMA_EN for a square-law brightness curve in every channel.
module led_fader
   import led_fader_pkg::*;
#(
   parameter int NUM_LEDS  = 4,
   parameter int PWM_BITS  = 8,
   parameter int PRESCALE  = 100,
   parameter int FADE_STEP = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_LEDS-1:0] in_pattern,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [NUM_LEDS-1:0] led_out,
   output logic [NUM_LEDS-1:0] fading,
   output logic                period_start
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]     prescaler;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic                wrap;

   assign tick = (prescaler == PS_W'(PRESCALE - 1));
   assign wrap = tick && (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler    <= '0;
         pwm_cnt      <= '0;
         period_start <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         end
         period_start <= wrap;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fader_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .pattern    (in_pattern[i]),
         .brightness (brightness),
         .pwm_cnt    (pwm_cnt),
         .wrap       (wrap),
         .led        (led_out[i]),
         .fading     (fading[i])
      );
   end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - directed self-checking bench for led_fader
// Expected PWM counts follow the square-law curve when LED_FADER_GAMMA_EN is defined.
module tb_led_fader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_pattern = 4'h0;
   logic [3:0] brightness = 4'd15;
   logic [3:0] led_out, fading, led_out3, fading3;
   logic       period_start, period_start3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_fader #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(1), .FADE_STEP(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_pattern   (in_pattern),
      .brightness   (brightness),
      .led_out      (led_out),
      .fading       (fading),
      .period_start (period_start)
   );

   led_fader #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(3), .FADE_STEP(4)) dut3 (
      .clk          (clk),
      .rst          (rst),
      .in_pattern   (in_pattern),
      .brightness   (brightness),
      .led_out      (led_out3),
      .fading       (fading3),
      .period_start (period_start3)
   );

   function automatic int eff(input int d);
`ifdef LED_FADER_GAMMA_EN
      return (d * d) >> 4;
`else
      return d;
`endif
   endfunction

   task automatic do_reset(input logic [3:0] pat, input logic [3:0] bri);
      rst = 1'b1;
      in_pattern = pat;
      brightness = bri;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ps(input string name);
      int n = 0;
      while (period_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (period_start !== 1'b1) begin
         errors++;
         $display("FAIL %s: period_start timeout, got %b want 1", name, period_start);
      end
   endtask

   // Observes the 16 samples following a period_start sample.
   task automatic run_period(input logic [3:0] pat, input logic [3:0] bri,
                             output int cnt0, output int cnt_hi,
                             output logic fad_all, output logic fad_any,
                             output logic fad_hi, output logic ps_ok);
      in_pattern = pat;
      brightness = bri;
      cnt0 = 0; cnt_hi = 0; fad_all = 1'b1; fad_any = 1'b0; fad_hi = 1'b0; ps_ok = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         cnt0   += int'(led_out[0]);
         cnt_hi += int'(led_out[1]) + int'(led_out[2]) + int'(led_out[3]);
         fad_all = fad_all & (fading[0] === 1'b1);
         fad_any = fad_any | (fading[0] === 1'b1);
         fad_hi  = fad_hi | (fading[3:1] !== 3'b000);
         if (period_start !== ((k == 16) ? 1'b1 : 1'b0)) ps_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_pattern = 4'hF;
      brightness = 4'd15;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rst = 1'b0;
         @(negedge clk);
         checks++;
         if ({led_out, fading, period_start} !== 9'b0) begin
            errors++;
            $display("FAIL reset[%0d]: led_out=%b fading=%b period_start=%b want all 0",
                     i, led_out, fading, period_start);
         end
      end
   endtask

   task automatic period_checks(input string name, input int idx, input int exp_cnt,
                                input logic exp_all, input logic exp_any,
                                input logic [3:0] pat, input logic [3:0] bri);
      int c0, chi;
      logic fa, fy, fh, pok;
      run_period(pat, bri, c0, chi, fa, fy, fh, pok);
      checks += 5;
      if (c0 !== exp_cnt) begin
         errors++;
         $display("FAIL %s[%0d] led0 high count: got %0d want %0d", name, idx, c0, exp_cnt);
      end
      if (chi !== 0) begin
         errors++;
         $display("FAIL %s[%0d] led1-3 high count: got %0d want 0", name, idx, chi);
      end
      if (fa !== exp_all || fy !== exp_any) begin
         errors++;
         $display("FAIL %s[%0d] fading0 all/any: got %b/%b want %b/%b", name, idx, fa, fy, exp_all, exp_any);
      end
      if (fh !== 1'b0) begin
         errors++;
         $display("FAIL %s[%0d] fading1-3: got active want 0", name, idx);
      end
      if (pok !== 1'b1) begin
         errors++;
         $display("FAIL %s[%0d] period_start timing: got misplaced want only on 16th cycle", name, idx);
      end
   endtask

   task automatic test_ramp_up();
      int   exp_d [4] = '{4, 8, 12, 15};
      logic exp_f [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset(4'b0001, 4'd15);
      wait_ps("ramp_up");
      for (int i = 0; i < 4; i++)
         period_checks("ramp_up", i, eff(exp_d[i]), exp_f[i], exp_f[i], 4'b0001, 4'd15);
   endtask

   task automatic test_ramp_down_reverse();
      logic [3:0] pats  [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
      int         exp_d [5] = '{15, 11, 7, 11, 15};
      logic       e_all [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       e_any [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++)
         period_checks("ramp_down", i, eff(exp_d[i]), e_all[i], e_any[i], pats[i], 4'd15);
   endtask

   task automatic test_brightness();
      logic [3:0] bris  [8] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
      int         exp_d [8] = '{15, 11, 8, 8, 8, 4, 0, 0};
      logic       e_all [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       e_any [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++)
         period_checks("brightness", i, eff(exp_d[i]), e_all[i], e_any[i], 4'b0001, bris[i]);
   endtask

   task automatic test_reset_mid_ramp();
      do_reset(4'b0001, 4'd15);
      wait_ps("mid_ramp");
      period_checks("mid_ramp_pre", 0, eff(4), 1'b1, 1'b1, 4'b0001, 4'd15);
      repeat (5) @(negedge clk);
      checks++;
      if (fading[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_ramp fading before reset: got %b want 1", fading[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (led_out !== 4'b0 || fading !== 4'b0 || period_start !== 1'b0) begin
         errors++;
         $display("FAIL mid_ramp reset outputs: led_out=%b fading=%b ps=%b want 0",
                  led_out, fading, period_start);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wait_ps("mid_ramp_restart");
      period_checks("mid_ramp_post", 0, eff(4), 1'b1, 1'b1, 4'b0001, 4'd15);
   endtask

   task automatic test_timebase();
      int n;
      int hi;
      int exp_d [2] = '{4, 8};
      do_reset(4'b0001, 4'd15);
      n = 0;
      while (period_start3 !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (period_start3 !== 1'b1) begin
         errors++;
         $display("FAIL timebase first wrap: got timeout want period_start");
      end
      for (int i = 0; i < 2; i++) begin
         n = 0;
         hi = 0;
         do begin
            @(negedge clk);
            n++;
            hi += int'(led_out3[0]);
         end while (period_start3 !== 1'b1 && n < 200);
         checks += 2;
         if (n !== 48) begin
            errors++;
            $display("FAIL timebase[%0d] period length: got %0d want 48", i, n);
         end
         if (hi !== 3 * eff(exp_d[i])) begin
            errors++;
            $display("FAIL timebase[%0d] led0 high cycles: got %0d want %0d", i, hi, 3 * eff(exp_d[i]));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down_reverse();
      test_brightness();
      test_reset_mid_ramp();
      test_timebase();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the LED blinker. Consumes the blinker's NUM_LEDS-wide on/off pattern and drives the board LEDs through per-channel PWM.
- Each channel ramps its brightness smoothly toward a target instead of hard-switching. The target is `brightness` when the pattern bit is 1, and 0 when it is 0.
- Sits between the blinker output and the top-level LED pins; single clock domain.

Parameters:
- NUM_LEDS, 4: channels; matches the blinker's OUTPUT_WIDTH.
- PWM_BITS, 8: PWM counter and duty width; PWM period is 2^PWM_BITS ticks.
- PRESCALE, 100: clk cycles per PWM tick; must be >= 1.
- FADE_STEP, 1: duty change per channel per PWM period; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_pattern  input  NUM_LEDS  on/off pattern from blinker; synchronous to clk.
- brightness  input  PWM_BITS  full-on duty level, shared by all channels.
- led_out  output  NUM_LEDS  registered PWM drive to LEDs.
- fading  output  NUM_LEDS  1 while channel is in RAMP_UP or RAMP_DOWN.
- period_start  output  1  one-cycle pulse on the tick where the PWM counter wraps to 0.

Behaviour:
- Reset (rst sampled high at a clk edge): the following all clear on the next cycle and stay clear while rst is high.
  - prescaler = 0, pwm_cnt = 0
  - all duty = 0, all target = 0, all channels OFF
  - led_out = 0, fading = 0, period_start = 0
- Reset mid-ramp aborts the ramp immediately; there is no completion.
- Prescaler:
  - Counts 0..PRESCALE-1; tick asserts when the count is PRESCALE-1, then the count returns to 0.
  - PRESCALE = 1 gives a tick every cycle.
- pwm_cnt:
  - Increments on tick; wraps from 2^PWM_BITS-1 to 0.
  - period_start is registered, high for the one cycle following the wrap.
- Target, per channel: registered each cycle as in_pattern[i] ? brightness : 0. One cycle latency.
- Duty update happens only on the wrap tick (glitch-free, one update per period):
  - duty < target: duty = min(duty + FADE_STEP, target).
  - duty > target: duty = max(duty - FADE_STEP, target).
  - Arithmetic in PWM_BITS+1 bits; saturating, never overshoots the target, never wraps.
- Per-channel state, derived combinationally from duty vs target and registered alongside duty:
  - OFF: duty == target == 0.
  - ON: duty == target != 0.
  - RAMP_UP: duty < target.
  - RAMP_DOWN: duty > target.
  - Any target change mid-ramp retargets at the next wrap; direction may reverse without passing through ON/OFF.
- Output: led_out[i] registered as (eff_duty[i] > pwm_cnt), one cycle after pwm_cnt.
  - duty 0: permanently low.
  - duty 2^PWM_BITS-1: high 2^PWM_BITS-1 of 2^PWM_BITS ticks.
- fading[i] = state is RAMP_UP or RAMP_DOWN; registered.
- brightness change while ON: the channel ramps to the new level. brightness = 0 with the pattern bit high yields OFF.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined: eff_duty = (duty * duty) >> PWM_BITS (perceptual square-law), computed combinationally. Compare latency is unchanged.
- Undefined: eff_duty = duty (linear). Duty, state and fading behaviour are identical in both builds.

Decomposition:
- Package led_fader_pkg:
  - typedef enum logic [1:0] fade_state_t {OFF, RAMP_UP, ON, RAMP_DOWN}.
  - Helper function sat_step(duty, target, step).
- Sub-module led_fader_channel, one instance per LED:
  - Holds target, duty, state, eff_duty, compare and led/fading registers.
  - Takes pwm_cnt and the wrap tick from the shared timebase in the parent.
- Parent holds the prescaler, pwm_cnt, period_start and the generate loop.

Test Plan (NUM_LEDS=4, PWM_BITS=4, PRESCALE=1, FADE_STEP=4, brightness=15, gamma off unless stated):
- Reset: hold rst 3 cycles with in_pattern=4'hF -> led_out=0, fading=0, period_start=0 throughout and 1 cycle after release.
- Ramp up: in_pattern=4'b0001 -> duty[0] takes 4, 8, 12, 15 at successive wraps (saturates at 15, not 16). fading[0]=1 until the 15 update, then 0. led_out[0] is high 4/16, 8/16, 12/16, then 15/16 cycles per period. Channels 1-3 stay low.
- Ramp down and reversal: from ON, clear bit 0 -> duty 11, 7. Set bit 0 again -> next wrap duty 11, RAMP_UP, no OFF visited.
- Timebase: PRESCALE=3 -> period_start every 48 cycles; pwm_cnt holds each value 3 cycles.
- Reset mid-ramp: assert rst when duty[0]=8 -> next cycle led_out=0, fading=0. After release, the ramp restarts from 0.
- Gamma (LED_FADER_GAMMA_EN): duty 8 -> eff_duty 4, led_out high 4/16 cycles. duty 15 -> eff_duty 14.
